freq_gate_ctrl: RTL
===================

Name: freq_gate_ctrl

Overview:
Measurement sequencer for the frequency meter. It generates the counter clear pulse, the counter gate window and the settle period, then evaluates the result. It also performs auto-ranging by driving the prescaler range select, and it latches the value for the LED scanner. It sits between the system clock domain, the BCD edge counter / range divider and the display module.

Parameters:
GATE_CYCLES, 100_000_000, clk cycles the gate (cnt_en) stays high; 1 s at 100 MHz
CLR_CYCLES, 2, clk cycles cnt_clr_n is held low before each gate
SETTLE_CYCLES, 4, clk cycles after the gate closes before cnt_value/cnt_ovf are sampled
LOW_THRESH, 16'h0900, BCD down-range threshold applied in range 1

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous, active-low reset
auto  input  1  1 = automatic ranging, 0 = manual
range_manual  input  1  range request when auto=0
cnt_value  input  16  4-digit BCD count from the edge counter
cnt_ovf  input  1  counter passed 9999 during the gate (sticky until clear)
cnt_clr_n  output  1  active-low counter clear
cnt_en  output  1  counter gate
range  output  1  prescaler select; 1 = signal divided by 10
disp_num  output  16  BCD value to the LED scanner
disp_valid  output  1  at least one result published since reset
over  output  1  displayed value is over-range

Behaviour:
- Clock port is clk. Reset port is reset_n, asynchronous and active-low. All outputs are registered.
- Reset values: cnt_clr_n=0, cnt_en=0, range=0, disp_num=16'h0000, disp_valid=0, over=0. State=CLEAR, timer loaded with CLR_CYCLES.
- Assertion mid-operation aborts the cycle immediately. The measurement restarts from CLEAR after release.
- FSM states: CLEAR -> GATE -> SETTLE -> EVAL -> CLEAR. Free-running, with no idle state.
  - CLEAR: cnt_clr_n=0, cnt_en=0 for exactly CLR_CYCLES cycles. On entry with auto=0, range <= range_manual.
  - GATE: cnt_clr_n=1, cnt_en=1 for exactly GATE_CYCLES cycles.
  - SETTLE: cnt_en=0 for SETTLE_CYCLES cycles.
  - EVAL: 1 cycle. cnt_value and cnt_ovf are sampled here, and the decision is registered on the edge that leaves EVAL.
- Period is CLR_CYCLES+GATE_CYCLES+SETTLE_CYCLES+1 clk cycles.
- range never changes during GATE or SETTLE.
- EVAL decision, auto=1, first match wins:
  - cnt_ovf=1 and range=0: range<=1, result discarded (disp_* unchanged).
  - cnt_ovf=1 and range=1: disp_num<=16'h9999, over<=1, disp_valid<=1.
  - cnt_ovf=0 and range=1 and cnt_value<LOW_THRESH: range<=0, result discarded.
  - Otherwise: disp_num<=cnt_value, over<=0, disp_valid<=1.
- EVAL decision, auto=0: never discards.
  - cnt_ovf=1: disp_num<=16'h9999, over<=1.
  - Otherwise: disp_num<=cnt_value, over<=0.
  - In both cases disp_valid<=1.
- BCD comparison is an unsigned compare of the 16-bit code, which is order-preserving for valid BCD. No binary conversion.
- Hysteresis: up-range above 9999 in range 0, down-range below 900 in range 1 (equivalent to 9000 in range 0). This prevents oscillation.
- auto and range_manual are sampled only at the EVAL and CLEAR-entry points respectively. Mid-cycle toggles take effect at the next such point.
- Timer is 27 bits wide, which covers GATE_CYCLES. It is reloaded on every state entry. Any parameter value below 1 is treated as 1.

Decomposition:
- Shared package freq_meter_pkg contains:
  - state encoding (CLEAR, GATE, SETTLE, EVAL; 2 bits)
  - BCD_MAX = 16'h9999
  - BCD_ZERO
  - the timer width constant.
- One sub-module: gate_timer. It is a loadable down-counter with load, load_value and done (count==1) outputs, and is instantiated once. The FSM and the range/result logic stay in freq_gate_ctrl.

Test Plan:
Bench parameters for all scenarios: GATE_CYCLES=10, CLR_CYCLES=2, SETTLE_CYCLES=2.
- Reset: assert reset_n=0 on cycle 5 of GATE -> all outputs return to reset values asynchronously. After release: cnt_clr_n low exactly 2 cycles, cnt_en high exactly 10 cycles, period 15 cycles.
- Normal measurement: auto=1, range=0, cnt_value=16'h1234, cnt_ovf=0 at EVAL -> next cycle disp_num=16'h1234, disp_valid=1, over=0, range=0.
- Up-range then settle: auto=1, cnt_ovf=1 in range 0 -> range=1, disp_num unchanged. Following cycle: cnt_value=16'h0950, ovf=0 -> disp_num=16'h0950, range stays 1.
- Down-range: range=1, cnt_value=16'h0500 -> range=0, result discarded. Separately, range=1 with cnt_ovf=1 -> disp_num=16'h9999, over=1.
- Manual mode: auto=0, range_manual 0->1 mid-GATE -> range stays 0 until the next CLEAR entry, then becomes 1. cnt_ovf=1 -> disp_num=16'h9999, over=1, range unchanged.

Source files
------------

// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the frequency meter control path.
package freq_meter_pkg;

    // Measurement sequencer states, in cycle order.
    typedef enum logic [1:0] {
        StClear  = 2'd0,
        StGate   = 2'd1,
        StSettle = 2'd2,
        StEval   = 2'd3
    } state_e;

    localparam int unsigned TIMER_W  = 27;
    localparam logic [15:0] BCD_MAX  = 16'h9999;
    localparam logic [15:0] BCD_ZERO = 16'h0000;

    // Phase lengths of zero would stall the sequencer; force them to at least one cycle.
    function automatic logic [TIMER_W-1:0] clamp_cycles(input int unsigned cycles);
        return (cycles < 1) ? TIMER_W'(1) : TIMER_W'(cycles);
    endfunction

endpackage

// File: rtl/gate_timer.sv
// Loadable down-counter timing each sequencer phase; done flags the last cycle of a phase.
module gate_timer
    import freq_meter_pkg::*;
#(
    parameter logic [TIMER_W-1:0] RESET_VALUE = TIMER_W'(1)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_value,
    output logic               done
);

    logic [TIMER_W-1:0] count_q;

    // Reload on phase entry, otherwise count down and hold at one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= RESET_VALUE;
        end else if (load) begin
            count_q <= load_value;
        end else if (count_q > TIMER_W'(1)) begin
            count_q <= count_q - TIMER_W'(1);
        end
    end

    assign done = (count_q == TIMER_W'(1));

endmodule

// File: rtl/freq_gate_ctrl.sv
// Frequency meter sequencer: counter clear, gate window, settle, then evaluation with
// auto-ranging and latching of the displayed value.
module freq_gate_ctrl
    import freq_meter_pkg::*;
#(
    parameter int unsigned GATE_CYCLES   = 100_000_000,
    parameter int unsigned CLR_CYCLES    = 2,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter logic [15:0] LOW_THRESH    = 16'h0900
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        auto,
    input  logic        range_manual,
    input  logic [15:0] cnt_value,
    input  logic        cnt_ovf,
    output logic        cnt_clr_n,
    output logic        cnt_en,
    output logic        range,
    output logic [15:0] disp_num,
    output logic        disp_valid,
    output logic        over
);

    localparam logic [TIMER_W-1:0] CLR_LD    = clamp_cycles(CLR_CYCLES);
    localparam logic [TIMER_W-1:0] GATE_LD   = clamp_cycles(GATE_CYCLES);
    localparam logic [TIMER_W-1:0] SETTLE_LD = clamp_cycles(SETTLE_CYCLES);
    localparam logic [TIMER_W-1:0] EVAL_LD   = TIMER_W'(1);

    state_e             state_q, state_d;
    logic               timer_load;
    logic [TIMER_W-1:0] timer_load_value;
    logic               timer_done;
    logic               eval_fire;

    logic               cnt_clr_n_q, cnt_en_q, range_q, range_d;
    logic [15:0]        disp_num_q, disp_num_d;
    logic               disp_valid_q, disp_valid_d, over_q, over_d;

    gate_timer #(
        .RESET_VALUE (CLR_LD)
    ) u_gate_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (timer_load),
        .load_value (timer_load_value),
        .done       (timer_done)
    );

    // Next state: advance on the last cycle of each phase and reload the timer for the next one.
    always_comb begin
        state_d          = state_q;
        timer_load       = 1'b0;
        timer_load_value = CLR_LD;
        if (timer_done) begin
            timer_load = 1'b1;
            case (state_q)
                StClear: begin
                    state_d          = StGate;
                    timer_load_value = GATE_LD;
                end
                StGate: begin
                    state_d          = StSettle;
                    timer_load_value = SETTLE_LD;
                end
                StSettle: begin
                    state_d          = StEval;
                    timer_load_value = EVAL_LD;
                end
                default: begin
                    state_d          = StClear;
                    timer_load_value = CLR_LD;
                end
            endcase
        end
    end

    // The edge leaving EVAL is also the CLEAR-entry edge, so range and result update together.
    assign eval_fire = (state_q == StEval) && timer_done;

    // Evaluation: auto-ranging with hysteresis, or manual range with every result published.
    always_comb begin
        range_d      = range_q;
        disp_num_d   = disp_num_q;
        disp_valid_d = disp_valid_q;
        over_d       = over_q;
        if (eval_fire) begin
            if (auto) begin
                if (cnt_ovf && !range_q) begin
                    range_d = 1'b1;
                end else if (cnt_ovf) begin
                    disp_num_d   = BCD_MAX;
                    over_d       = 1'b1;
                    disp_valid_d = 1'b1;
                end else if (range_q && (cnt_value < LOW_THRESH)) begin
                    range_d = 1'b0;
                end else begin
                    disp_num_d   = cnt_value;
                    over_d       = 1'b0;
                    disp_valid_d = 1'b1;
                end
            end else begin
                range_d      = range_manual;
                disp_num_d   = cnt_ovf ? BCD_MAX : cnt_value;
                over_d       = cnt_ovf;
                disp_valid_d = 1'b1;
            end
        end
    end

    // State and registered outputs; counter controls follow the state being entered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StClear;
            cnt_clr_n_q  <= 1'b0;
            cnt_en_q     <= 1'b0;
            range_q      <= 1'b0;
            disp_num_q   <= BCD_ZERO;
            disp_valid_q <= 1'b0;
            over_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_clr_n_q  <= (state_d != StClear);
            cnt_en_q     <= (state_d == StGate);
            range_q      <= range_d;
            disp_num_q   <= disp_num_d;
            disp_valid_q <= disp_valid_d;
            over_q       <= over_d;
        end
    end

    assign cnt_clr_n  = cnt_clr_n_q;
    assign cnt_en     = cnt_en_q;
    assign range      = range_q;
    assign disp_num   = disp_num_q;
    assign disp_valid = disp_valid_q;
    assign over       = over_q;

endmodule
